// File: rtl/axil_mem_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to mem request/ack bridge.
// The FSM encoding and the AXI response codes live here so the top and any future siblings agree.
package axil_mem_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWReq,
    StWResp,
    StRReq,
    StRResp
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/axil_skid_slot.sv
// One-entry valid/ready holding register. The entry is held until pop_i, and ready is registered
// so it stays low while reset is asserted and for the first cycle afterwards.
module axil_skid_slot #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  input  logic             pop_i
);

  logic             full_q, full_d;
  logic             ready_q;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (pop_i) begin
        full_d = 1'b0;
      end
    end else if (valid_i && ready_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axil_mem_bridge.sv
// AXI4-Lite slave bridging to a single-outstanding mem_w/mem_r request/ack interface, with
// alignment/strobe checks and a per-access timeout that turns a missing ack into SLVERR.
module axil_mem_bridge
  import axil_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic                    mem_w_req,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [DATA_WIDTH-1:0]   mem_w_data,
  input  logic                    mem_w_ack,
  output logic                    mem_r_req,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_data,
  input  logic                    mem_r_ack
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  last_was_write_q, last_was_write_d;

  logic                  aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [StrbW-1:0]      w_strb;
  logic                  pop_wr, pop_rd;
  logic                  wr_ready, rd_ready, grant_wr;

  axil_skid_slot #(
    .Width(ADDR_WIDTH)
  ) u_aw_slot (
    .clk_i  (clk),
    .rst_ni (rst),
    .valid_i(s_awvalid),
    .ready_o(s_awready),
    .data_i (s_awaddr),
    .valid_o(aw_full),
    .data_o (aw_addr),
    .pop_i  (pop_wr)
  );

  axil_skid_slot #(
    .Width(DATA_WIDTH + StrbW)
  ) u_w_slot (
    .clk_i  (clk),
    .rst_ni (rst),
    .valid_i(s_wvalid),
    .ready_o(s_wready),
    .data_i ({s_wstrb, s_wdata}),
    .valid_o(w_full),
    .data_o ({w_strb, w_data}),
    .pop_i  (pop_wr)
  );

  axil_skid_slot #(
    .Width(ADDR_WIDTH)
  ) u_ar_slot (
    .clk_i  (clk),
    .rst_ni (rst),
    .valid_i(s_arvalid),
    .ready_o(s_arready),
    .data_i (s_araddr),
    .valid_o(ar_full),
    .data_o (ar_addr),
    .pop_i  (pop_rd)
  );

  assign wr_ready = aw_full && w_full;
  assign rd_ready = ar_full;
  // Round-robin on a tie: serve whichever kind did not go last.
  assign grant_wr = wr_ready && (!rd_ready || !last_was_write_q);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bresp_d          = bresp_q;
    rresp_d          = rresp_q;
    rdata_d          = rdata_q;
    last_was_write_d = last_was_write_q;
    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          last_was_write_d = 1'b1;
          if (!word_aligned(aw_addr[1:0]) || (w_strb != {StrbW{1'b1}})) begin
            bresp_d = RESP_SLVERR;
            state_d = StWResp;
          end else begin
            cnt_d   = '0;
            state_d = StWReq;
          end
        end else if (rd_ready) begin
          last_was_write_d = 1'b0;
          if (!word_aligned(ar_addr[1:0])) begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
            state_d = StRResp;
          end else begin
            cnt_d   = '0;
            state_d = StRReq;
          end
        end
      end
      StWReq: begin
        // Ack is checked before the abort so a last-cycle ack still completes as OKAY.
        if (mem_w_ack) begin
          bresp_d = RESP_OKAY;
          state_d = StWResp;
        end else if (cnt_q == CntLast) begin
          bresp_d = RESP_SLVERR;
          state_d = StWResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWResp: begin
        if (s_bready) begin
          state_d = StIdle;
        end
      end
      StRReq: begin
        if (mem_r_ack) begin
          rresp_d = RESP_OKAY;
          rdata_d = mem_r_data;
          state_d = StRResp;
        end else if (cnt_q == CntLast) begin
          rresp_d = RESP_SLVERR;
          rdata_d = '0;
          state_d = StRResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRResp: begin
        if (s_rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slots free on entry to the response state so the next request can be captured during B/R.
  assign pop_wr = (state_d == StWResp) && (state_q != StWResp);
  assign pop_rd = (state_d == StRResp) && (state_q != StRResp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      bresp_q          <= RESP_OKAY;
      rresp_q          <= RESP_OKAY;
      rdata_q          <= '0;
      last_was_write_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bresp_q          <= bresp_d;
      rresp_q          <= rresp_d;
      rdata_q          <= rdata_d;
      last_was_write_q <= last_was_write_d;
    end
  end

  assign mem_w_req  = (state_q == StWReq);
  assign mem_r_req  = (state_q == StRReq);
  assign mem_w_addr = aw_addr;
  assign mem_w_data = w_data;
  assign mem_r_addr = ar_addr;
  assign s_bvalid   = (state_q == StWResp);
  assign s_rvalid   = (state_q == StRResp);
  assign s_bresp    = bresp_q;
  assign s_rresp    = rresp_q;
  assign s_rdata    = rdata_q;

endmodule

// File: tb/tb_axil_mem_bridge.sv
// Randomized scoreboard bench for axil_mem_bridge: a word-array reference model predicts each
// response, a downstream device model acks requests, and a monitor checks B/R beats in order.
module tb_axil_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_rvalid, s_rready;
  logic        mem_w_req, mem_w_ack, mem_r_req, mem_r_ack;
  logic [31:0] mem_w_addr, mem_w_data, mem_r_addr, mem_r_data;

  axil_mem_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .mem_w_req (mem_w_req),
    .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data),
    .mem_w_ack (mem_w_ack),
    .mem_r_req (mem_r_req),
    .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data),
    .mem_r_ack (mem_r_ack)
  );

  always #5 clk = ~clk;

  localparam int NumMapped = 12;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          ack_en  = 1'b1;
  bit          rand_rdy = 1'b0;
  logic [31:0] ref_mem [16];
  logic [31:0] dev_mem [16];
  bit   [15:0] dev_wr;
  bit          wpend, rpend;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  bit          order_q[$];
  int          w_req_cycles = 0, r_req_cycles = 0, w_len = 0, last_w_len = 0;
  int          lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int idx);
    return 32'hA500_0000 | 32'(idx);
  endfunction

  // Downstream device: acks one cycle after it first sees a request.
  initial begin
    mem_w_ack = 1'b0; mem_r_ack = 1'b0; mem_r_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_w_ack = 1'b0;
      mem_r_ack = 1'b0;
      if (!rst) begin
        wpend = 1'b0; rpend = 1'b0;
      end else begin
        if (wpend) begin
          mem_w_ack = 1'b1;
          wpend = 1'b0;
          if (int'(mem_w_addr[5:2]) < NumMapped) begin
            dev_mem[mem_w_addr[5:2]] = mem_w_data;
            dev_wr[mem_w_addr[5:2]]  = 1'b1;
          end
        end else if (mem_w_req && ack_en) begin
          wpend = 1'b1;
        end
        if (rpend) begin
          mem_r_ack = 1'b1;
          rpend = 1'b0;
          if (int'(mem_r_addr[5:2]) >= NumMapped) mem_r_data = 32'h0BAD_CAFE;
          else if (dev_wr[mem_r_addr[5:2]]) mem_r_data = dev_mem[mem_r_addr[5:2]];
          else mem_r_data = init_val(int'(mem_r_addr[5:2]));
        end else if (mem_r_req && ack_en) begin
          rpend = 1'b1;
        end
      end
    end
  end

  // Response-side readies: always-on for directed tests, random backpressure later.
  initial begin
    s_bready = 1'b1; s_rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        s_bready = ($urandom_range(0, 3) != 0);
        s_rready = ($urandom_range(0, 3) != 0);
      end else begin
        s_bready = 1'b1; s_rready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    bit          b_stall = 1'b0, r_stall = 1'b0;
    logic [1:0]  b_hold;
    logic [33:0] r_hold, e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        b_stall = 1'b0; r_stall = 1'b0; w_len = 0;
      end else begin
        w_req_cycles += int'(mem_w_req);
        r_req_cycles += int'(mem_r_req);
        if (mem_w_req) w_len++;
        else if (w_len != 0) begin last_w_len = w_len; w_len = 0; end
        if (mem_w_req || mem_r_req) check("req_exclusive", mem_w_req && mem_r_req, 0);
        if (b_stall) check("b_stable", {s_bvalid, s_bresp}, {1'b1, b_hold});
        if (r_stall) check("r_stable", {s_rvalid, s_rresp, s_rdata}, {1'b1, r_hold});
        b_stall = s_bvalid && !s_bready;
        b_hold  = s_bresp;
        r_stall = s_rvalid && !s_rready;
        r_hold  = {s_rresp, s_rdata};
        if (s_bvalid && s_bready) begin
          order_q.push_back(1'b1);
          if (exp_b.size() == 0) check("b_unexpected", 1, 0);
          else check("bresp", s_bresp, exp_b.pop_front());
        end
        if (s_rvalid && s_rready) begin
          order_q.push_back(1'b0);
          if (exp_r.size() == 0) check("r_unexpected", 1, 0);
          else begin
            e = exp_r.pop_front();
            check("rresp", s_rresp, e[33:32]);
            check("rdata", s_rdata, e[31:0]);
          end
        end
      end
    end
  end

  // Reference model: expectations derived from the bridge's rules on a word array.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    if (addr[1:0] != 2'b00 || strb != 4'hF || !ack_en) begin
      exp_b.push_back(2'b10);
    end else begin
      exp_b.push_back(2'b00);
      if (int'(addr[5:2]) < NumMapped) ref_mem[addr[5:2]] = data;
    end
  endtask

  task automatic model_read(input logic [31:0] addr);
    if (addr[1:0] != 2'b00 || !ack_en) exp_r.push_back({2'b10, 32'h0});
    else if (int'(addr[5:2]) >= NumMapped) exp_r.push_back({2'b00, 32'h0BAD_CAFE});
    else exp_r.push_back({2'b00, ref_mem[addr[5:2]]});
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [31:0] waddr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] raddr, input bit measure, output int l);
    bit aw_ok, w_ok, ar_ok;
    int n = 0;
    s_awaddr = waddr; s_wdata = wdata; s_wstrb = wstrb; s_araddr = raddr;
    s_awvalid = wr; s_wvalid = wr; s_arvalid = rd;
    while ((s_awvalid || s_wvalid || s_arvalid) && n < 200) begin
      @(negedge clk);
      aw_ok = s_awvalid && s_awready;
      w_ok  = s_wvalid && s_wready;
      ar_ok = s_arvalid && s_arready;
      @(posedge clk); #1;
      if (aw_ok) s_awvalid = 1'b0;
      if (w_ok)  s_wvalid  = 1'b0;
      if (ar_ok) s_arvalid = 1'b0;
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", 1, 0);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    end
    l = 0;
    if (measure) begin
      while (!(wr ? s_bvalid : s_rvalid) && l < 60) begin
        @(posedge clk); #1;
        l++;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      check("drain_timeout", 1, 0);
      exp_b.delete(); exp_r.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wr_op(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output int l);
    model_write(addr, data, strb);
    drive(1'b1, 1'b0, addr, data, strb, 32'h0, 1'b1, l);
    wait_drain();
  endtask

  task automatic rd_op(input logic [31:0] addr, output int l);
    model_read(addr);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, addr, 1'b1, l);
    wait_drain();
  endtask

  initial begin
    int          wc, rc;
    logic [3:0]  ord;
    logic [31:0] a, d;
    logic [3:0]  st;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_valids", {s_bvalid, s_rvalid}, 0);
    check("rst_resps", {s_bresp, s_rresp}, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_reqs", {mem_w_req, mem_r_req}, 0);
    rst = 1'b1;

    wr_op(32'h04, 32'hDEAD_BEEF, 4'hF, lat);
    check("write_latency", lat, 3);
    rd_op(32'h04, lat);
    check("read_latency", lat, 3);

    wc = w_req_cycles;
    wr_op(32'h08, 32'h1234_5678, 4'h3, lat);
    check("badstrb_no_wreq", w_req_cycles - wc, 0);
    rd_op(32'h08, lat);

    rc = r_req_cycles;
    rd_op(32'h06, lat);
    check("unaligned_no_rreq", r_req_cycles - rc, 0);

    ack_en = 1'b0;
    wr_op(32'h10, 32'h5555_AAAA, 4'hF, lat);
    check("timeout_wreq_len", last_w_len, 16);
    rd_op(32'h10, lat);
    ack_en = 1'b1;
    rd_op(32'h10, lat);
    rd_op(32'h34, lat);

    order_q.delete();
    for (int k = 0; k < 2; k++) begin
      model_write(32'h14 + 32'(k * 8), 32'hC0DE_0000 + 32'(k), 4'hF);
      model_read(32'h18 + 32'(k * 8));
      drive(1'b1, 1'b1, 32'h14 + 32'(k * 8), 32'hC0DE_0000 + 32'(k), 4'hF,
            32'h18 + 32'(k * 8), 1'b0, lat);
      wait_drain();
    end
    check("arb_count", order_q.size(), 4);
    ord = 4'h0;
    for (int k = 0; k < 4 && k < order_q.size(); k++) ord[3-k] = order_q[k];
    check("arb_order", ord, 4'b1010);

    ack_en = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0C, 1'b0, lat);
    for (int i = 0; i < 10 && !mem_r_req; i++) begin
      @(posedge clk); #1;
    end
    check("rreq_before_reset", mem_r_req, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_rreq", mem_r_req, 0);
    check("rst_mid_rvalid", s_rvalid, 0);
    check("rst_mid_readies", {s_awready, s_wready, s_arready}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    ack_en = 1'b1;
    rd_op(32'h0C, lat);
    check("post_reset_latency", lat, 3);
    rd_op(32'h04, lat);

    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      ack_en = ($urandom_range(0, 9) != 0);
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom;
      st = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      if ($urandom_range(0, 1) == 1) wr_op(a, d, st, lat);
      else rd_op(a, lat);
    end
    ack_en = 1'b1;
    rand_rdy = 1'b0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
